dmem_bridge: RTL and testbench
==============================

Name: dmem_bridge

Overview:
- Data-memory bridge directly downstream of the riscv core's memory stage.
- Consumes the core's M-stage access: mem_write, mem_read, address, write data and bit mask.
- Converts each access into a single registered request/acknowledge transaction on an external memory bus.
- Returns read_data to the core and holds stall_read high until the access completes or times out.

Parameters:
- XLEN, 32, data/address width (matches core `XLEN).
- TIMEOUT, 255, BUSY cycles without bus_ack before the access is aborted (1..2^CNT_W-1).
- CNT_W, 8, width of the timeout counter.
- ERR_DATA, 32'hDEAD_BEEF, read_data value returned on a timed-out read.

Ports:
- clk  input  1  core clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_write  input  1  core MemWrite (M stage).
- mem_read  input  1  core MemReadM.
- addr  input  XLEN  core ALUResultM, byte address.
- wdata  input  XLEN  core WriteData.
- mask  input  XLEN  core bit-level write mask.
- read_data  output  XLEN  to core ReadData.
- stall_read  output  1  to core stallRead.
- bus_req  output  1  transaction request, registered.
- bus_we  output  1  1 = write, 0 = read, registered.
- bus_addr  output  XLEN  word-aligned address, {addr[XLEN-1:2],2'b00}, registered.
- bus_wdata  output  XLEN  registered write data.
- bus_wstrb  output  XLEN/8  byte strobes, bus_wstrb[i] = |mask[8i+7:8i], registered.
- bus_ack  input  1  one-cycle completion pulse from memory.
- bus_rdata  input  XLEN  read data, valid only with bus_ack.
- bus_err  output  1  one-cycle pulse when an access times out.

Behaviour:
- Reset values: state IDLE; bus_req, bus_we, bus_err = 0; bus_addr, bus_wdata, bus_wstrb, read_data = 0; counter = 0.
- Reset asserted mid-transaction aborts it immediately. bus_req drops asynchronously and no completion is reported.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If mem_read|mem_write: latch addr/wdata/wstrb/we, set bus_req = 1, clear the counter, go to BUSY.
  - If both mem_read and mem_write are high, the write wins (bus_we = 1) and read_data is unchanged.
- BUSY:
  - bus_req is held high with stable bus_addr/bus_we/bus_wdata/bus_wstrb until bus_ack.
  - On bus_ack: on a read, read_data <= bus_rdata. Drop bus_req and go to DONE.
  - Otherwise the counter increments. When the counter == TIMEOUT and there is no ack: drop bus_req, pulse bus_err for 1 cycle, load read_data <= ERR_DATA on a read, go to DONE.
  - An ack arriving in the same cycle as the timeout wins; no bus_err.
- DONE: lasts exactly 1 cycle, then IDLE. New requests are not sampled in DONE, so the still-present M-stage access is not re-issued.
- stall_read is combinational: (IDLE && (mem_read|mem_write)) || BUSY. It is 0 in DONE and whenever IDLE has no request.
- Latency:
  - Request seen in cycle 0; bus_req high in cycle 1; ack earliest in cycle 1; DONE in cycle 2 (stall_read = 0).
  - Minimum of 2 stall cycles per access; each cycle of extra ack delay adds 1.
- read_data is registered and holds its last completed value until the next read completes. Writes never modify it.
- bus_ack in IDLE or DONE is ignored; there is no state change.
- A back-to-back access in the cycle after DONE starts a new transaction from IDLE normally.
- Counter wrap-around is impossible: the counter is cleared on entry to BUSY and is bounded by TIMEOUT.

Test Plan:
- Read, ack in the 1st BUSY cycle:
  - Stimulus: addr=0x0000_1006, mem_read=1; bus_rdata=0x1234_5678 with ack.
  - Response: bus_addr=0x0000_1004, bus_we=0; stall_read high 2 cycles; read_data=0x1234_5678 in DONE.
- Byte write, ack after 3 BUSY cycles:
  - Stimulus: mask=0x0000_FF00, wdata=0x0000_AB00, mem_write=1.
  - Response: bus_wstrb=4'b0010; bus_req stable 3 cycles; stall_read high 4 cycles; read_data unchanged.
- Timeout with TIMEOUT=4, no ack on a read:
  - Response: bus_req drops after 5 BUSY cycles; bus_err pulses once; read_data=0xDEAD_BEEF; stall_read released in DONE.
- Ack in the same cycle as the timeout:
  - Response: read_data=bus_rdata; bus_err stays 0.
- Stray and back-to-back traffic:
  - Stimulus: stray bus_ack in IDLE; then two consecutive loads with the request held through DONE.
  - Response: no state change on the stray ack; exactly two bus transactions, not three.
- Reset mid-transaction:
  - Stimulus: assert reset during BUSY.
  - Response: bus_req=0 immediately, state IDLE, read_data=0; the next read proceeds normally.

Source files
------------

// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns the core's M-stage load/store into one registered
// request/acknowledge transaction on an external memory bus, with an ack timeout.
module dmem_bridge #(
  parameter int              XLEN     = 32,
  parameter int              TIMEOUT  = 255,
  parameter int              CNT_W    = 8,
  parameter logic [XLEN-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   mask,
  output logic [XLEN-1:0]   read_data,
  output logic              stall_read,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_wstrb,
  input  logic              bus_ack,
  input  logic [XLEN-1:0]   bus_rdata,
  output logic              bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [XLEN-1:0] ADDR_ALIGN = ~XLEN'(3);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [XLEN-1:0]   r_bus_addr;
  logic [XLEN-1:0]   r_bus_wdata;
  logic [XLEN/8-1:0] r_bus_wstrb;
  logic              r_bus_err;
  logic [XLEN-1:0]   r_read_data;

  logic              w_req;
  logic [XLEN/8-1:0] w_wstrb;

  assign w_req = mem_read | mem_write;

  // A byte lane is written if any bit of its mask byte is set.
  always_comb begin
    w_wstrb = '0;
    for (int i = 0; i < XLEN/8; i++) begin
      w_wstrb[i] = |mask[8*i +: 8];
    end
  end

  // NOTE: every register here uses non-blocking assignment so all state updates
  // see the pre-edge values; the reset branch clears everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wstrb <= '0;
      r_bus_err   <= 1'b0;
      r_read_data <= '0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= mem_write;
            r_bus_addr  <= addr & ADDR_ALIGN;
            r_bus_wdata <= wdata;
            r_bus_wstrb <= w_wstrb;
            r_cnt       <= '0;
            r_state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus_ack) begin
            if (!r_bus_we) r_read_data <= bus_rdata;
            r_bus_req <= 1'b0;
            r_state   <= S_DONE;
          end else if (r_cnt == CNT_LIMIT) begin
            if (!r_bus_we) r_read_data <= ERR_DATA;
            r_bus_req <= 1'b0;
            r_bus_err <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        // One dead cycle so the access still held in M is not re-issued.
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall_read = ((r_state == S_IDLE) && w_req) || (r_state == S_BUSY);
  assign bus_req    = r_bus_req;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;
  assign bus_wstrb  = r_bus_wstrb;
  assign bus_err    = r_bus_err;
  assign read_data  = r_read_data;

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: table of accesses with a scoreboard of completion
// results, plus hand-written stray-ack, back-to-back and mid-access reset cases.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write, mem_read;
  logic [31:0] addr, wdata, mask;
  logic [31:0] read_data;
  logic        stall_read;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  dmem_bridge #(.XLEN(32), .TIMEOUT(4), .CNT_W(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset),
    .mem_write(mem_write), .mem_read(mem_read),
    .addr(addr), .wdata(wdata), .mask(mask),
    .read_data(read_data), .stall_read(stall_read),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        re, we;
    logic [31:0] addr, wdata, mask, rdata;
    int          ack_at;   // BUSY cycle (1-based) carrying the ack; 0 = never
    logic        hold;     // keep the request asserted through DONE
    logic [31:0] x_addr;
    logic        x_we;
    logic [3:0]  x_strb;
    int          x_stall;
    logic [31:0] x_rd;
    logic        x_err;
  } vec_t;

  typedef struct {
    int          stall;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   txn_cnt = 0;
  logic prev_req = 1'b0;

  always @(negedge clk) begin
    if (bus_req && !prev_req) txn_cnt++;
    prev_req = bus_req;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic re, we, input logic [31:0] a, wd, m, rd,
                               input int ack_at, input logic hold,
                               input logic [31:0] xa, input logic xwe, input logic [3:0] xs,
                               input int xst, input logic [31:0] xrd, input logic xerr);
    vec_t v;
    v.re = re; v.we = we; v.addr = a; v.wdata = wd; v.mask = m; v.rdata = rd;
    v.ack_at = ack_at; v.hold = hold; v.x_addr = xa; v.x_we = xwe; v.x_strb = xs;
    v.x_stall = xst; v.x_rd = xrd; v.x_err = xerr;
    return v;
  endfunction

  task automatic do_access(input vec_t v);
    exp_t e;
    int   n;
    logic bad;
    @(negedge clk);
    mem_read = v.re; mem_write = v.we; addr = v.addr; wdata = v.wdata; mask = v.mask;
    sb.push_back('{v.x_stall, v.x_rd, v.x_err});
    #1;
    n = 0;
    bad = 1'b0;
    while (stall_read && n < 300) begin
      n++;
      if (n == 2) begin
        check("bus_req", {31'b0, bus_req}, 32'd1);
        check("bus_we", {31'b0, bus_we}, {31'b0, v.x_we});
        check("bus_addr", bus_addr, v.x_addr);
        check("bus_wstrb", {28'b0, bus_wstrb}, {28'b0, v.x_strb});
        check("bus_wdata", bus_wdata, v.wdata);
      end else if (n > 2) begin
        if (bus_req !== 1'b1 || bus_we !== v.x_we || bus_addr !== v.x_addr ||
            bus_wstrb !== v.x_strb || bus_wdata !== v.wdata || bus_err !== 1'b0) bad = 1'b1;
      end
      if (v.ack_at > 0 && n - 1 == v.ack_at) begin
        bus_ack = 1'b1;
        bus_rdata = v.rdata;
      end
      @(negedge clk);
      bus_ack = 1'b0;
      bus_rdata = $urandom;
      #1;
    end
    check("done_bound", {31'b0, stall_read}, 32'd0);
    check("bus_hold", {31'b0, bad}, 32'd0);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("stall_cycles", n, e.stall);
      check("read_data", read_data, e.rd);
      check("bus_err", {31'b0, bus_err}, {31'b0, e.err});
      check("req_dropped", {31'b0, bus_req}, 32'd0);
    end
    if (!v.hold) begin
      mem_read = 1'b0;
      mem_write = 1'b0;
      @(negedge clk);
      #1;
      check("err_pulse_1cyc", {31'b0, bus_err}, 32'd0);
    end
  endtask

  vec_t vecs[8];
  vec_t hv;
  int   t0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mkv(1, 0, 32'h0000_1006, 32'h0, 32'h0, 32'h1234_5678, 1, 0,
                  32'h0000_1004, 0, 4'b0000, 2, 32'h1234_5678, 0);
    vecs[1] = mkv(0, 1, 32'h0000_2000, 32'h0000_AB00, 32'h0000_FF00, 32'h0, 3, 0,
                  32'h0000_2000, 1, 4'b0010, 4, 32'h1234_5678, 0);
    vecs[2] = mkv(1, 0, 32'h0000_3008, 32'h0, 32'h0, 32'h0, 0, 0,
                  32'h0000_3008, 0, 4'b0000, 6, 32'hDEAD_BEEF, 1);
    vecs[3] = mkv(1, 0, 32'h0000_400F, 32'h0, 32'h0, 32'hCAFE_0001, 5, 0,
                  32'h0000_400C, 0, 4'b0000, 6, 32'hCAFE_0001, 0);
    vecs[4] = mkv(1, 1, 32'h0000_5001, 32'h1122_3344, 32'hFFFF_FFFF, 32'h9999_9999, 2, 0,
                  32'h0000_5000, 1, 4'b1111, 3, 32'hCAFE_0001, 0);
    vecs[5] = mkv(0, 1, 32'h0000_6000, 32'h7700_0000, 32'hFF00_0000, 32'h0, 0, 0,
                  32'h0000_6000, 1, 4'b1000, 6, 32'hCAFE_0001, 1);
    vecs[6] = mkv(1, 0, 32'h0000_7FFE, 32'h0, 32'h0, 32'h0BAD_F00D, 4, 0,
                  32'h0000_7FFC, 0, 4'b0000, 5, 32'h0BAD_F00D, 0);
    vecs[7] = mkv(0, 1, 32'h0000_0008, 32'h0055_0066, 32'h0001_0080, 32'h0, 1, 0,
                  32'h0000_0008, 1, 4'b0101, 2, 32'h0BAD_F00D, 0);

    reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0;
    addr = '0; wdata = '0; mask = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_bus_req", {31'b0, bus_req}, 32'd0);
    check("rst_bus_err", {31'b0, bus_err}, 32'd0);
    check("rst_read_data", read_data, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wstrb", {28'b0, bus_wstrb}, 32'd0);
    check("rst_stall", {31'b0, stall_read}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) do_access(vecs[i]);

    // Stray ack while idle must be ignored.
    @(negedge clk);
    bus_ack = 1'b1;
    bus_rdata = 32'hFFFF_0000;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check("stray_req", {31'b0, bus_req}, 32'd0);
    check("stray_stall", {31'b0, stall_read}, 32'd0);
    check("stray_rd", read_data, 32'h0BAD_F00D);
    check("stray_err", {31'b0, bus_err}, 32'd0);

    // Two loads with the request held through DONE: exactly two transactions.
    t0 = txn_cnt;
    hv = mkv(1, 0, 32'h0000_A000, 32'h0, 32'h0, 32'h1111_0000, 1, 1,
             32'h0000_A000, 0, 4'b0000, 2, 32'h1111_0000, 0);
    do_access(hv);
    hv = mkv(1, 0, 32'h0000_A004, 32'h0, 32'h0, 32'h2222_0000, 2, 0,
             32'h0000_A004, 0, 4'b0000, 3, 32'h2222_0000, 0);
    do_access(hv);
    repeat (3) @(negedge clk);
    #1;
    check("b2b_txn_count", txn_cnt - t0, 2);
    check("b2b_idle_req", {31'b0, bus_req}, 32'd0);

    // Reset asserted in BUSY aborts the access immediately.
    @(negedge clk);
    mem_read = 1'b1;
    addr = 32'h0000_9000;
    @(negedge clk);
    #1;
    check("mid_busy_req", {31'b0, bus_req}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_req", {31'b0, bus_req}, 32'd0);
    check("mid_rst_rd", read_data, 32'd0);
    mem_read = 1'b0;
    #1;
    check("mid_rst_stall", {31'b0, stall_read}, 32'd0);
    @(negedge clk);
    #1;
    check("mid_rst_err", {31'b0, bus_err}, 32'd0);
    reset = 1'b0;
    hv = mkv(1, 0, 32'h0000_9002, 32'h0, 32'h0, 32'h5555_AAAA, 1, 0,
             32'h0000_9000, 0, 4'b0000, 2, 32'h5555_AAAA, 0);
    do_access(hv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
